rr_arbiter8: RTL



---
 rtl/rr_arbiter8_pkg.sv | 13 +
 rtl/decoder.sv | 9 +
 rtl/rr_pick8.sv | 27 ++
 rtl/rr_arbiter8.sv | 93 +++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package rr_arbiter8_pkg;

    localparam int ARB_N      = 8;
    localparam int ARB_IDX_W  = 3;
    localparam int ARB_HOLD_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - 3-to-8 one-hot decoder
module decoder (
    input  logic [2:0] x,
    output logic [7:0] y
);

    assign y = 8'b0000_0001 << x;

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick: first set request after ptr, modulo 8
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] idx,
    output logic                 valid
);

    logic [ARB_IDX_W-1:0] cand;

    // Walk from farthest (ptr itself) to nearest (ptr+1) so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = ARB_N; k >= 1; k--) begin
            cand = ptr + ARB_IDX_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter granting one shared resource to one of 8 requesters
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     grant,
    output logic [ARB_IDX_W-1:0] grant_idx,
    output logic                 busy,
    output logic                 timeout
);

    localparam logic [ARB_HOLD_W-1:0] HOLD_LIMIT = ARB_HOLD_W'(MAX_HOLD - 1);

    arb_state_e             state, state_n;
    logic [ARB_IDX_W-1:0]   ptr, ptr_n;
    logic [ARB_IDX_W-1:0]   idx_n;
    logic [ARB_HOLD_W-1:0]  cnt, cnt_n;
    logic                   timeout_n;
    logic [ARB_IDX_W-1:0]   pick_idx;
    logic                   pick_valid;
    logic [ARB_N-1:0]       dec_y;
    logic                   rel_done, rel_drop, rel_limit;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    decoder u_dec (
        .x (grant_idx),
        .y (dec_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= 3'd7;
            grant_idx <= '0;
            cnt       <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_idx <= idx_n;
            cnt       <= cnt_n;
            timeout   <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = grant_idx;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        rel_done  = 1'b0;
        rel_drop  = 1'b0;
        rel_limit = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    idx_n   = pick_idx;
                    ptr_n   = pick_idx;
                    cnt_n   = '0;
                    state_n = ARB_OWN;
                end
            end
            ARB_OWN: begin
                cnt_n     = cnt + 1'b1;
                rel_done  = done;
                rel_drop  = ~req[grant_idx];
                rel_limit = (cnt == HOLD_LIMIT);
                if (rel_done || rel_drop || rel_limit) begin
                    state_n   = ARB_IDLE;
                    // Timeout is reported only when the limit alone forced the release.
                    timeout_n = rel_limit & ~rel_done & ~rel_drop;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign busy  = (state == ARB_OWN);
    assign grant = dec_y & {ARB_N{busy}};

endmodule
